alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream stage of the ALU/RAM controller. Accepts ALU commands (op + two operands) over a
//  valid/ready port and buffers them in a small FIFO. Issues them one at a time to the
//  controller with a 1-cycle start pulse, holding the operands stable until done returns.
//  Counts completed commands and flags a controller that never answers.
// PARAMETERS
//  DATA_W   8   operand width
//  OP_W     3   ALU opcode width
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  TIMEOUT  15  max cycles in S_WAIT before abandoning a command (must exceed 5)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command present on cmd_*
//  cmd_ready    out  1       FIFO can accept (= !full)
//  cmd_op       in   OP_W    opcode
//  cmd_a        in   DATA_W  operand A
//  cmd_b        in   DATA_W  operand B
//  start        out  1       1-cycle pulse to controller
//  alu_op       out  OP_W    registered opcode to ALU input regs
//  alu_a        out  DATA_W  registered operand A
//  alu_b        out  DATA_W  registered operand B
//  done         in   1       controller completion (high one cycle in its DONE state)
//  busy         out  1       (state != S_IDLE) || FIFO not empty
//  op_count     out  8       completed commands, wraps 255->0
//  timeout_err  out  1       sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset (async, reset=0): FIFO empty, state S_IDLE, start/alu_*/op_count/timeout_err/wait cnt = 0;
//   so cmd_ready=1, busy=0. Reset mid-command discards FIFO and in-flight command.
//  Push: cmd_valid && cmd_ready. When full, cmd_ready=0 even if a pop occurs this cycle (no bypass).
//  FSM (registered state):
//   S_IDLE : FIFO not empty -> load alu_op/a/b from FIFO head (registered), -> S_ISSUE.
//   S_ISSUE: start=1 (exactly this cycle); operands already stable; clear wait cnt; -> S_WAIT.
//   S_WAIT : wait cnt++ per cycle. done=1 -> pop head, op_count++, -> S_IDLE.
//            else wait cnt == TIMEOUT -> pop head (drop), timeout_err<=1, op_count unchanged, -> S_IDLE.
//            done and timeout same cycle: done wins.
//  done outside S_WAIT is ignored. alu_* hold value until next S_IDLE->S_ISSUE load.
//  Push and pop in same cycle: both occur, occupancy unchanged.
//  Latency: command into empty idle FIFO at edge t -> start high in cycle t+2;
//   with nominal controller done arrives 5 cycles after start; back-to-back start spacing = 7 cycles.
//  Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
// STRUCTURE
//  Package alu_seq_pkg: seq_state_t enum {S_IDLE=2'b00, S_ISSUE=2'b01, S_WAIT=2'b10};
//   command struct {op, a, b}; default DATA_W/OP_W constants.
//  Sub-module cmd_fifo: synchronous FIFO (push/pop/full/empty/head), width OP_W+2*DATA_W,
//   depth DEPTH, same clk/reset. FSM, counters and output regs live in the top.
// TESTING
//  Reset then single cmd (op=3,a=8'h12,b=8'h34), done 5 cycles after start -> one start pulse,
//   alu_a=12/alu_b=34 stable through done, op_count=1, busy=0 afterwards.
//  Push 4 cmds back-to-back, withhold done -> cmd_ready=0 after 4th; 5th push refused.
//  Drain 4 cmds with model controller -> 4 start pulses, order preserved, op_count=4, start spacing 7.
//  Never assert done -> at TIMEOUT (15 cycles in S_WAIT) entry dropped, timeout_err=1 sticky,
//   next cmd still issued; op_count unchanged.
//  Assert reset mid S_WAIT with 3 cmds queued -> all outputs zero, cmd_ready=1, busy=0, no start.
//  256 completions -> op_count wraps to 0; spurious done in S_IDLE -> no count change.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer.
//   seq_state_t : sequencer FSM encoding
//   cmd_t       : one ALU command {op, a, b} at the default widths
package alu_seq_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } seq_state_t;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding packed ALU commands.
//   clk, reset  : rising-edge clock, async active-low reset (empties the FIFO)
//   push, wdata : write one entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   full, empty : occupancy flags, both registered-state decodes
//   head        : current head entry, valid while !empty
module cmd_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // full/empty come from registered occupancy, so a same-cycle pop never frees a slot early
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands and issues them one at a time to the ALU/RAM controller.
//   clk, reset          : rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready : command input handshake; cmd_ready = FIFO not full
//   cmd_op/cmd_a/cmd_b  : command fields
//   start               : 1-cycle issue pulse to the controller
//   alu_op/alu_a/alu_b  : registered operands, held until the next command loads
//   done                : controller completion, only honoured while waiting
//   busy                : command in flight or queued
//   op_count            : completed commands, wraps at 256
//   timeout_err         : sticky, set when a command is abandoned
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              done,
  output logic              busy,
  output logic [7:0]        op_count,
  output logic              timeout_err
);
  localparam int CMD_W = OP_W + 2*DATA_W;
  localparam int CW    = $clog2(TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [7:0]        op_count_q, op_count_d;
  logic              timeout_err_q, timeout_err_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0]  fifo_head;

  assign fifo_push = cmd_valid && !fifo_full;

  cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The head stays in the FIFO while in flight; it is only popped on done or timeout.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    op_count_d    = op_count_q;
    timeout_err_d = timeout_err_q;
    fifo_pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          alu_op_d = fifo_head[CMD_W-1 -: OP_W];
          alu_a_d  = fifo_head[2*DATA_W-1 -: DATA_W];
          alu_b_d  = fifo_head[DATA_W-1:0];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        // done takes priority over an expiring timer in the same cycle
        if (done) begin
          fifo_pop   = 1'b1;
          op_count_d = op_count_q + 8'd1;
          state_d    = S_IDLE;
        end else if (wait_cnt_q == CW'(TIMEOUT)) begin
          fifo_pop      = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      op_count_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      op_count_q    <= op_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign start       = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign op_count    = op_count_q;
  assign timeout_err = timeout_err_q;
endmodule
